// File: rtl/transmit_protocol_pkg.sv
// Shared definitions for the transmit_protocol serial framer: frame geometry,
// line levels, counter constants and the one-hot state encoding.
// Optional build feature: TX_HOLD_BUF_EN (one-entry holding buffer).
package transmit_protocol_pkg;

  localparam int PKT_W     = 55;  // packet width in bits
  localparam int PRE_ONES  = 5;   // 1 bits that follow the leading 0 of the preamble
  localparam int GAP       = 1;   // idle cycles after the last data bit (1..7)
  localparam int CNT_W     = 7;   // shared down-counter width
  localparam int FRAME_LEN = 1 + PRE_ONES + PKT_W + GAP;

  localparam logic [5:0] PREAMBLE   = 6'b011111;
  localparam logic       IDLE_LEVEL = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = 7'd0;
  localparam logic [CNT_W-1:0] CNT_ONE   = 7'd1;
  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_ONES - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(PKT_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP - 1);

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_START = 5'b00010,
    ST_PRE   = 5'b00100,
    ST_DATA  = 5'b01000,
    ST_GAP   = 5'b10000
  } state_t;

endpackage

// File: rtl/transmit_protocol_if.sv
// Packet handshake and serial-line bundle of the transmit_protocol framer.
// master: packet source side; slave: the framer itself.
interface transmit_protocol_if;
  import transmit_protocol_pkg::*;

  logic [PKT_W-1:0] packet;
  logic             send;
  logic             ready;
  logic             S_Data;
  logic             busy;
  logic             done;

  modport master (
    output packet, send,
    input  ready, S_Data, busy, done
  );

  modport slave (
    input  packet, send,
    output ready, S_Data, busy, done
  );

endinterface

// File: rtl/transmit_protocol_hold_buf.sv
// One-entry valid/data holding register for the transmit_protocol framer.
// Only compiled in when TX_HOLD_BUF_EN is defined; a load has priority over
// a pop (the framer never requests both in the same cycle).
`ifdef TX_HOLD_BUF_EN
module transmit_protocol_hold_buf
  import transmit_protocol_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_pop,
  input  logic [PKT_W-1:0] i_data,
  output logic             o_valid,
  output logic [PKT_W-1:0] o_data
);

  logic             r_valid;
  logic [PKT_W-1:0] r_data;

  // Buffer state: capture on load, release on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {PKT_W{1'b0}};
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`endif

// File: rtl/transmit_protocol.sv
// Serial framer: sends a 0, PRE_ONES ones, the packet MSB first, then GAP idle
// ones on S_Data. All outputs come from registers, so the line level and done
// are computed from the next state and land together with it.
// Optional build feature: TX_HOLD_BUF_EN adds a one-entry holding buffer so a
// packet can be accepted mid-frame and started straight after the gap.
module transmit_protocol
  import transmit_protocol_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  transmit_protocol_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PKT_W-1:0] r_shift;
  logic [PKT_W-1:0] w_shift_nxt;

  logic             r_sdata;
  logic             r_done;
  logic             r_busy;
  logic             w_sdata_nxt;
  logic             w_done_nxt;

  logic             w_ready;
  logic             w_accept;
  logic             w_pend_valid;
  logic [PKT_W-1:0] w_pend_data;

`ifdef TX_HOLD_BUF_EN
  logic w_buf_load;
  logic w_buf_pop;

  // Ready tracks buffer occupancy; an accept outside IDLE parks the packet.
  assign w_ready    = ~w_pend_valid;
  assign w_accept   = bus.send & w_ready;
  assign w_buf_load = w_accept & (r_state != ST_IDLE);
  // Pop exactly when the next-state logic takes the buffered packet.
  assign w_buf_pop  = w_pend_valid &
                      ((r_state == ST_IDLE) | ((r_state == ST_GAP) & (r_cnt == CNT_ZERO)));

  transmit_protocol_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_pop   (w_buf_pop),
    .i_data  (bus.packet),
    .o_valid (w_pend_valid),
    .o_data  (w_pend_data)
  );
`else
  logic r_ready;

  // Ready register: high only while the next state is IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b1;
    end else begin
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  assign w_ready      = r_ready;
  assign w_accept     = bus.send & w_ready;
  assign w_pend_valid = 1'b0;
  assign w_pend_data  = {PKT_W{1'b0}};
`endif

  // State register: FSM state, shared down-counter and packet shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_shift <= {PKT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic: walk START -> PRE -> DATA -> GAP, reloading the counter per phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_valid) begin
          w_state_nxt = ST_START;
          w_shift_nxt = w_pend_data;
        end else if (w_accept) begin
          w_state_nxt = ST_START;
          w_shift_nxt = bus.packet;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_state_nxt = ST_PRE;
        w_cnt_nxt   = PRE_LOAD;
      end
      ST_PRE: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = DATA_LOAD;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      ST_DATA: begin
        // The MSB of the shift register is the bit on the line; advance it.
        w_shift_nxt = {r_shift[PKT_W-2:0], 1'b0};
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_ZERO) begin
          if (w_pend_valid) begin
            w_state_nxt = ST_START;
            w_shift_nxt = w_pend_data;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_shift_nxt = {PKT_W{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so the registered line matches the state it enters.
  always_comb begin
    w_sdata_nxt = IDLE_LEVEL;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      ST_IDLE:  w_sdata_nxt = IDLE_LEVEL;
      ST_START: w_sdata_nxt = PREAMBLE[5];
      ST_PRE:   w_sdata_nxt = PREAMBLE[0];
      ST_DATA: begin
        w_sdata_nxt = w_shift_nxt[PKT_W-1];
        w_done_nxt  = (w_cnt_nxt == CNT_ZERO);
      end
      ST_GAP:   w_sdata_nxt = IDLE_LEVEL;
      default:  w_sdata_nxt = IDLE_LEVEL;
    endcase
  end

  // Output registers: line level, last-bit pulse and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sdata <= IDLE_LEVEL;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sdata <= w_sdata_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.ready  = w_ready;
  assign bus.S_Data = r_sdata;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
